i2s_dac_bridge: RTL and testbench
=================================

Name: i2s_dac_bridge

Overview:
- Parametrised successor of the I2S-to-DAC serializer. Runs entirely on mck_i and oversamples the I2S bck/lrck/data lines instead of clocking logic on bck.
- Captures DATA_W-bit stereo samples in I2S or left-justified format, with optional offset-binary conversion.
- Queues one pending sample per channel and shifts each out as a CMD_W+DATA_W SPI frame (sync/sclk/sdo) to the dual DAC.
- Sits between the audio source pins and the DAC SPI pins.

Parameters:
DATA_W, 24, sample bits captured per channel (16..32); extra slot bits are ignored
CMD_W, 8, command prefix width
CMD_L, 8'h08, command prefix for left-channel frames
CMD_R, 8'h09, command prefix for right-channel frames
INIT_WORD, 32'h06FFFFFF, configuration frame sent once after reset (width CMD_W+DATA_W)
SCLK_DIV, 2, mck_i cycles per sclk half-period (>=1)
SYNC_HI, 4, minimum mck_i cycles sync_o stays high between frames

Ports:
mck_i  in  1  system clock; all logic is clocked on its rising edge
rst_i  in  1  asynchronous active-high reset
bck_i  in  1  I2S bit clock (asynchronous, oversampled)
lrck_i  in  1  I2S word select
data_i  in  1  I2S serial data
fmt_i  in  1  0 = I2S (one-bit delay, lrck low = left); 1 = left-justified (no delay, lrck high = left)
offset_bin_i  in  1  1 = invert sample MSB (two's complement to offset binary)
sclk_o  out  1  DAC serial clock, idles high
sync_o  out  1  DAC frame sync, active low
sdo_o  out  1  DAC serial data
busy_o  out  1  high while a frame or gap is in progress
overrun_o  out  1  one-cycle pulse when a pending sample is overwritten

Behaviour:
- Reset, asynchronous and applied immediately, including mid-frame: sclk_o=1, sync_o=1, sdo_o=0, busy_o=0, overrun_o=0. All pending flags, the capture register and the bit counters clear. Any frame in progress is aborted.
- Input conditioning: bck_i, lrck_i and data_i each pass through a 2-flop synchronizer. A bck rise is detected when the synced value is 1 and the previous synced value was 0. All sampling happens on detected bck rises.
- Channel start: at a bck rise where the synced lrck differs from the lrck sampled at the previous rise.
  - LJ: this rise is bit 0 (the MSB).
  - I2S: the next rise is bit 0.
- Capture: bits 0..DATA_W-1 shift in MSB-first. After the DATA_W-th bit the word is complete: the MSB is inverted if offset_bin_i=1, the word is written to the L or R pending register, and that channel's pend flag is set.
  - If the slot ends (channel start) before DATA_W bits, the captured bits are left-aligned, the LSBs are zero-padded, and the word is delivered at the channel start.
  - fmt_i and offset_bin_i are sampled at each channel start.
- Overrun: a word delivered to a channel whose pend flag is still set overwrites it and pulses overrun_o for one cycle.
- TX FSM states: INIT, IDLE, SHIFT, GAP.
  - INIT is entered when reset is released. It loads INIT_WORD and goes to SHIFT.
  - IDLE: if pend_L, load {CMD_L, L}, clear pend_L and go to SHIFT. Otherwise, if pend_R, load {CMD_R, R}. Left wins when both are pending. A word arriving in the same cycle as the load of the same channel counts as a new pend (no overrun).
  - SHIFT:
    - On entry: sync_o=0, sdo_o=frame MSB, sclk_o=1.
    - Every SCLK_DIV cycles sclk_o toggles. The falling edge is the DAC sample point; on the rising edge sdo_o advances to the next bit.
    - After the CMD_W+DATA_W-th fall, plus one half-period: sclk_o=1, sync_o=1, sdo_o=0, go to GAP.
    - sync_o is low for exactly 2*SCLK_DIV*(CMD_W+DATA_W) cycles.
  - GAP: hold for SYNC_HI cycles, then go to IDLE.
  - busy_o is high in INIT, SHIFT and GAP.
- Capture continues independently of TX. A new word never disturbs a frame being shifted.

Test Plan:
- Release reset, no I2S activity -> one frame with sdo_o bits = 0x06FFFFFF MSB-first; sync_o low for 128 mck cycles (SCLK_DIV=2); then busy_o=0 and sync_o=1.
- I2S, offset_bin_i=1, L=0x123456, R=0x800000, bck=mck/8 -> frames 0x08923456 then 0x09000000; no overrun_o.
- LJ (fmt_i=1), offset_bin_i=0, L=0xABCDEF, 32-bit slots -> frame 0x08ABCDEF; trailing slot bits ignored.
- 16-bit slot with DATA_W=24, L=0x7FFF -> frame 0x087FFF00, delivered at the channel start.
- SCLK_DIV=64, so frames take longer than a slot; continuous stereo -> overrun_o pulses on overwritten words; transmitted frames carry the newest value.
- Assert rst_i during bit 10 of a frame -> sync_o=1, sclk_o=1, sdo_o=0 immediately; INIT frame resent after release.

Source files
------------

// File: rtl/i2s_dac_bridge.sv
`timescale 1ns/1ps
// Oversampled I2S / left-justified stereo capture on mck_i, feeding an SPI
// serializer for a dual DAC; sends a configuration frame once after reset.
module i2s_dac_bridge #(
    parameter int                      DATA_W    = 24,
    parameter int                      CMD_W     = 8,
    parameter logic [CMD_W-1:0]        CMD_L     = 8'h08,
    parameter logic [CMD_W-1:0]        CMD_R     = 8'h09,
    parameter logic [CMD_W+DATA_W-1:0] INIT_WORD = 32'h06FFFFFF,
    parameter int                      SCLK_DIV  = 2,
    parameter int                      SYNC_HI   = 4
) (
    input  logic mck_i,
    input  logic rst_i,
    input  logic bck_i,
    input  logic lrck_i,
    input  logic data_i,
    input  logic fmt_i,
    input  logic offset_bin_i,
    output logic sclk_o,
    output logic sync_o,
    output logic sdo_o,
    output logic busy_o,
    output logic overrun_o
);

    localparam int FW    = CMD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TXB_W = $clog2(FW);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GAP_W = (SYNC_HI > 1) ? $clog2(SYNC_HI) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} tx_state_t;

    function automatic logic [DATA_W-1:0] to_offset(input logic [DATA_W-1:0] w, input logic en);
        to_offset = {w[DATA_W-1] ^ en, w[DATA_W-2:0]};
    endfunction

    logic bck_p0, bck_p1, bck_p2;
    logic lrck_p0, lrck_p1;
    logic data_p0, data_p1;

    always_ff @(posedge mck_i or posedge rst_i) begin
        if (rst_i) begin
            bck_p0  <= 1'b0;
            bck_p1  <= 1'b0;
            bck_p2  <= 1'b0;
            lrck_p0 <= 1'b0;
            lrck_p1 <= 1'b0;
            data_p0 <= 1'b0;
            data_p1 <= 1'b0;
        end else begin
            bck_p0  <= bck_i;
            bck_p1  <= bck_p0;
            bck_p2  <= bck_p1;
            lrck_p0 <= lrck_i;
            lrck_p1 <= lrck_p0;
            data_p0 <= data_i;
            data_p1 <= data_p0;
        end
    end

    // Capture stage: bits shift in at the LSB end; a short slot is left-aligned on delivery.
    logic              bck_rise, ch_start;
    logic              lr_prev, slot_act, slot_left, slot_offb;
    logic [CNT_W-1:0]  cap_cnt;
    logic [DATA_W-1:0] cap_sr, cap_next, cap_part;
    logic              wr_vld, wr_left;
    logic [DATA_W-1:0] wr_word;

    assign bck_rise = bck_p1 & ~bck_p2;
    assign ch_start = lrck_p1 ^ lr_prev;
    assign cap_next = {cap_sr[DATA_W-2:0], data_p1};
    assign cap_part = cap_sr << (CNT_W'(DATA_W) - cap_cnt);

    always_ff @(posedge mck_i or posedge rst_i) begin
        if (rst_i) begin
            lr_prev   <= 1'b0;
            slot_act  <= 1'b0;
            slot_left <= 1'b0;
            slot_offb <= 1'b0;
            cap_cnt   <= '0;
            cap_sr    <= '0;
            wr_vld    <= 1'b0;
            wr_left   <= 1'b0;
            wr_word   <= '0;
        end else begin
            wr_vld <= 1'b0;
            if (bck_rise) begin
                lr_prev <= lrck_p1;
                if (ch_start) begin
                    if (slot_act && cap_cnt != '0 && cap_cnt != CNT_W'(DATA_W)) begin
                        wr_vld  <= 1'b1;
                        wr_left <= slot_left;
                        wr_word <= to_offset(cap_part, slot_offb);
                    end
                    slot_act  <= 1'b1;
                    slot_left <= fmt_i ? lrck_p1 : ~lrck_p1;
                    slot_offb <= offset_bin_i;
                    // Left-justified: this rise already carries the MSB.
                    cap_sr    <= fmt_i ? DATA_W'(data_p1) : '0;
                    cap_cnt   <= fmt_i ? CNT_W'(1) : '0;
                end else if (slot_act && cap_cnt != CNT_W'(DATA_W)) begin
                    cap_sr  <= cap_next;
                    cap_cnt <= cap_cnt + 1'b1;
                    if (cap_cnt == CNT_W'(DATA_W - 1)) begin
                        wr_vld  <= 1'b1;
                        wr_left <= slot_left;
                        wr_word <= to_offset(cap_next, slot_offb);
                    end
                end
            end
        end
    end

    // Pending samples and SPI transmit stage.
    tx_state_t         state;
    logic              pend_l, pend_r;
    logic [DATA_W-1:0] smp_l, smp_r;
    logic [FW-2:0]     frame_sr;
    logic [DIV_W-1:0]  div_cnt;
    logic [TXB_W-1:0]  tx_bit;
    logic [GAP_W-1:0]  gap_cnt;
    logic              load_l, load_r, tx_load;
    logic [FW-1:0]     tx_word;

    assign load_l = (state == ST_IDLE) && pend_l;
    assign load_r = (state == ST_IDLE) && !pend_l && pend_r;

    always_comb begin
        tx_load = 1'b0;
        tx_word = INIT_WORD;
        if (state == ST_INIT) begin
            tx_load = 1'b1;
        end else if (load_l) begin
            tx_load = 1'b1;
            tx_word = {CMD_L, smp_l};
        end else if (load_r) begin
            tx_load = 1'b1;
            tx_word = {CMD_R, smp_r};
        end
    end

    always_ff @(posedge mck_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_INIT;
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
            smp_l     <= '0;
            smp_r     <= '0;
            frame_sr  <= '0;
            div_cnt   <= '0;
            tx_bit    <= '0;
            gap_cnt   <= '0;
            sclk_o    <= 1'b1;
            sync_o    <= 1'b1;
            sdo_o     <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (load_l) pend_l <= 1'b0;
            if (load_r) pend_r <= 1'b0;
            // A word landing on the cycle its channel is loaded is a fresh pend, not an overrun.
            if (wr_vld) begin
                if (wr_left) begin
                    smp_l     <= wr_word;
                    pend_l    <= 1'b1;
                    overrun_o <= pend_l && !load_l;
                end else begin
                    smp_r     <= wr_word;
                    pend_r    <= 1'b1;
                    overrun_o <= pend_r && !load_r;
                end
            end

            if (tx_load) begin
                frame_sr <= tx_word[FW-2:0];
                sdo_o    <= tx_word[FW-1];
                sync_o   <= 1'b0;
                sclk_o   <= 1'b1;
                busy_o   <= 1'b1;
                div_cnt  <= '0;
                tx_bit   <= '0;
                state    <= ST_SHIFT;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                            div_cnt <= '0;
                            if (sclk_o) begin
                                sclk_o <= 1'b0;
                            end else if (tx_bit == TXB_W'(FW - 1)) begin
                                sclk_o  <= 1'b1;
                                sync_o  <= 1'b1;
                                sdo_o   <= 1'b0;
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end else begin
                                sclk_o   <= 1'b1;
                                tx_bit   <= tx_bit + 1'b1;
                                sdo_o    <= frame_sr[FW-2];
                                frame_sr <= {frame_sr[FW-3:0], 1'b0};
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_W'(SYNC_HI - 1)) begin
                            busy_o <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_bridge.sv
`timescale 1ns/1ps
// Randomized bench for i2s_dac_bridge: drives I2S/LJ streams and decodes the
// SPI frames of a fast (SCLK_DIV=2) and a slow (SCLK_DIV=64) instance.
module tb_i2s_dac_bridge;

    localparam logic [31:0] INIT_W = 32'h06FFFFFF;

    logic mck = 1'b0, rst = 1'b1, bck = 1'b0, lrck = 1'b0, sdata = 1'b0, fmt = 1'b0, offb = 1'b0;
    logic sclk_a, sync_a, sdo_a, busy_a, ovr_a;
    logic sclk_b, sync_b, sdo_b, busy_b, ovr_b;

    int n_chk = 0, n_fail = 0;

    always #5 mck = ~mck;

    i2s_dac_bridge #(.DATA_W(24), .CMD_W(8), .CMD_L(8'h08), .CMD_R(8'h09),
                     .INIT_WORD(32'h06FFFFFF), .SCLK_DIV(2), .SYNC_HI(4)) u_fast (
        .mck_i(mck), .rst_i(rst), .bck_i(bck), .lrck_i(lrck), .data_i(sdata),
        .fmt_i(fmt), .offset_bin_i(offb), .sclk_o(sclk_a), .sync_o(sync_a),
        .sdo_o(sdo_a), .busy_o(busy_a), .overrun_o(ovr_a));

    i2s_dac_bridge #(.DATA_W(24), .CMD_W(8), .CMD_L(8'h08), .CMD_R(8'h09),
                     .INIT_WORD(32'h06FFFFFF), .SCLK_DIV(64), .SYNC_HI(4)) u_slow (
        .mck_i(mck), .rst_i(rst), .bck_i(bck), .lrck_i(lrck), .data_i(sdata),
        .fmt_i(fmt), .offset_bin_i(offb), .sclk_o(sclk_b), .sync_o(sync_b),
        .sdo_o(sdo_b), .busy_o(busy_b), .overrun_o(ovr_b));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI frame decoders: bits taken on sclk falls while sync is low.
    logic [31:0] rx_a[$], rx_b[$];
    int len_a[$], len_b[$], nb_q_a[$], nb_q_b[$];
    int ovr_a_n = 0, ovr_b_n = 0, nb_a = 0, nb_b = 0;

    initial begin : mon_a
        logic [31:0] acc;
        int low;
        logic sclk_p, sync_p;
        acc = 0; low = 0; sclk_p = 1; sync_p = 1;
        forever begin
            @(negedge mck);
            if (rst) begin
                acc = 0; low = 0; nb_a = 0;
            end else begin
                if (ovr_a) ovr_a_n++;
                if (!sync_a) begin
                    low++;
                    if (sclk_p && !sclk_a) begin acc = {acc[30:0], sdo_a}; nb_a++; end
                end else if (!sync_p) begin
                    rx_a.push_back(acc); len_a.push_back(low); nb_q_a.push_back(nb_a);
                    acc = 0; low = 0; nb_a = 0;
                end
            end
            sclk_p = sclk_a; sync_p = sync_a;
        end
    end

    initial begin : mon_b
        logic [31:0] acc;
        int low;
        logic sclk_p, sync_p;
        acc = 0; low = 0; sclk_p = 1; sync_p = 1;
        forever begin
            @(negedge mck);
            if (rst) begin
                acc = 0; low = 0; nb_b = 0;
            end else begin
                if (ovr_b) ovr_b_n++;
                if (!sync_b) begin
                    low++;
                    if (sclk_p && !sclk_b) begin acc = {acc[30:0], sdo_b}; nb_b++; end
                end else if (!sync_p) begin
                    rx_b.push_back(acc); len_b.push_back(low); nb_q_b.push_back(nb_b);
                    acc = 0; low = 0; nb_b = 0;
                end
            end
            sclk_p = sclk_b; sync_p = sync_b;
        end
    end

    // Reference: a slot keeps its first min(n,24) bits, zero-padded, MSB optionally flipped.
    function automatic logic [31:0] exp_frame(input logic [31:0] slot, input bit left, input int n, input bit ob);
        logic [23:0] w;
        w = slot[31:8];
        if (n < 24) w = (w >> (24 - n)) << (24 - n);
        if (ob) w[23] = ~w[23];
        return {left ? 8'h08 : 8'h09, w};
    endfunction

    logic [31:0] slot_q[$];

    task automatic play(input bit lj, input int n, input int half);
        bit lr_seq[$];
        bit d_seq[$];
        logic [31:0] v;
        bit left, lr;
        for (int i = 0; i < 4; i++) begin lr_seq.push_back(1'b0); d_seq.push_back(1'b0); end
        if (!lj) begin lr_seq.push_back(1'b1); d_seq.push_back(1'b0); end
        for (int s = 0; s < slot_q.size(); s++) begin
            v = slot_q[s];
            left = (s % 2 == 0);
            lr = lj ? left : !left;
            for (int b = 0; b < n; b++) begin lr_seq.push_back(lr); d_seq.push_back(v[31-b]); end
        end
        lr = !lr_seq[lr_seq.size()-1];
        for (int i = 0; i < 2; i++) begin lr_seq.push_back(lr); d_seq.push_back(1'b0); end
        if (!lj) begin d_seq.push_front(1'b0); d_seq.delete(d_seq.size()-1); end
        fmt = lj;
        for (int i = 0; i < lr_seq.size(); i++) begin
            bck = 1'b0; lrck = lr_seq[i]; sdata = d_seq[i];
            #(half * 10);
            bck = 1'b1;
            #(half * 10);
        end
        bck = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge mck);
        check_eq("rst_outs_fast", {sclk_a, sync_a, sdo_a, busy_a, ovr_a}, 5'b11000);
        check_eq("rst_outs_slow", {sclk_b, sync_b, sdo_b, busy_b, ovr_b}, 5'b11000);
        rx_a.delete(); len_a.delete(); nb_q_a.delete(); ovr_a_n = 0;
        rx_b.delete(); len_b.delete(); nb_q_b.delete(); ovr_b_n = 0;
        bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic wait_rx_a(input int n, input int budget);
        int t;
        t = 0;
        while (rx_a.size() < n && t < budget) begin @(negedge mck); t++; end
        if (rx_a.size() < n) check_eq("rx_timeout", 64'(rx_a.size()), 64'(n));
    endtask

    task automatic check_fast(input logic [31:0] exp_q[$]);
        wait_rx_a(exp_q.size(), 4000);
        repeat (300) @(negedge mck);
        check_eq("frame_cnt", 64'(rx_a.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_a.size(); i++) begin
            check_eq($sformatf("frame%0d", i), rx_a[i], exp_q[i]);
            check_eq($sformatf("sync_len%0d", i), 64'(len_a[i]), 64'd128);
            check_eq($sformatf("nbits%0d", i), 64'(nb_q_a[i]), 64'd32);
        end
        check_eq("no_overrun", 64'(ovr_a_n), 64'd0);
    endtask

    task automatic run_std(input bit lj, input int n, input int half, input bit ob);
        logic [31:0] exp_q[$];
        apply_reset();
        offb = ob;
        exp_q.push_back(INIT_W);
        for (int s = 0; s < slot_q.size(); s++) exp_q.push_back(exp_frame(slot_q[s], s % 2 == 0, n, ob));
        play(lj, n, half);
        check_fast(exp_q);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] lw[$], rw[$];
        logic [31:0] f, last_l, last_r;
        int li, ri, j, idle, t;

        // Configuration frame after reset, with no I2S activity.
        apply_reset();
        wait_rx_a(1, 400);
        if (rx_a.size() > 0) begin
            check_eq("init_frame", rx_a[0], 32'h06FFFFFF);
            check_eq("init_sync_len", 64'(len_a[0]), 64'd128);
        end
        repeat (8) @(negedge mck);
        check_eq("idle_busy_sync", {busy_a, sync_a, sclk_a}, 3'b011);

        // I2S, offset binary, bck = mck/8, junk in the trailing slot bits.
        slot_q.delete();
        slot_q.push_back({24'h123456, 8'($urandom)});
        slot_q.push_back({24'h800000, 8'($urandom)});
        for (int i = 0; i < 6; i++) slot_q.push_back($urandom);
        run_std(1'b0, 32, 4, 1'b1);
        if (rx_a.size() > 2) begin
            check_eq("i2s_L", rx_a[1], 32'h08923456);
            check_eq("i2s_R", rx_a[2], 32'h09000000);
        end

        // Left-justified, two's complement, 32-bit slots.
        slot_q.delete();
        slot_q.push_back({24'hABCDEF, 8'($urandom)});
        for (int i = 0; i < 5; i++) slot_q.push_back($urandom);
        run_std(1'b1, 32, 3, 1'b0);
        if (rx_a.size() > 1) check_eq("lj_L", rx_a[1], 32'h08ABCDEF);

        // 16-bit slots: words are zero-padded and delivered at the next channel start.
        slot_q.delete();
        slot_q.push_back(32'h7FFF0000);
        for (int i = 0; i < 3; i++) slot_q.push_back($urandom);
        run_std(1'b1, 16, 4, 1'b0);
        if (rx_a.size() > 1) check_eq("short_L", rx_a[1], 32'h087FFF00);

        // Reset in the middle of bit 10 of the configuration frame.
        apply_reset();
        t = 0;
        while (nb_a < 10 && t < 200) begin @(negedge mck); t++; end
        check_eq("reached_bit10", 64'(nb_a), 64'd10);
        #3 rst = 1'b1;
        #1 check_eq("midframe_rst", {sclk_a, sync_a, sdo_a, busy_a}, 4'b1100);
        repeat (3) @(negedge mck);
        rx_a.delete(); len_a.delete(); nb_q_a.delete();
        #2 rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(INIT_W);
        check_fast(exp_q);

        // Continuous stereo into the slow instance: frames outlast slots, so words get overwritten.
        slot_q.delete();
        for (int i = 0; i < 40; i++) slot_q.push_back($urandom);
        lw.delete(); rw.delete();
        exp_q.delete();
        exp_q.push_back(INIT_W);
        for (int s = 0; s < 40; s++) begin
            f = exp_frame(slot_q[s], s % 2 == 0, 32, 1'b0);
            exp_q.push_back(f);
            if (s % 2 == 0) lw.push_back(f); else rw.push_back(f);
        end
        apply_reset();
        offb = 1'b0;
        play(1'b0, 32, 4);
        idle = 0; t = 0;
        while (idle < 3 && t < 20000) begin
            @(negedge mck);
            t++;
            idle = busy_b ? 0 : idle + 1;
        end
        check_eq("slow_drained", 64'(idle >= 3), 64'd1);
        check_fast(exp_q);
        check_eq("slow_init", (rx_b.size() > 0) ? rx_b[0] : 32'h0, INIT_W);
        if (len_b.size() > 0) check_eq("slow_sync_len", 64'(len_b[0]), 64'd4096);
        check_eq("slow_overrun_seen", 64'(ovr_b_n > 0), 64'd1);
        check_eq("slow_accounting", 64'(rx_b.size() - 1 + ovr_b_n), 64'd40);
        li = -1; ri = -1; last_l = 32'h0; last_r = 32'h0;
        for (int i = 1; i < rx_b.size(); i++) begin
            f = rx_b[i];
            j = -1;
            if (f[31:24] == 8'h08) begin
                for (int k = li + 1; k < lw.size(); k++) if (lw[k] == f) begin j = k; break; end
                if (j >= 0) li = j;
                last_l = f;
            end else begin
                for (int k = ri + 1; k < rw.size(); k++) if (rw[k] == f) begin j = k; break; end
                if (j >= 0) ri = j;
                last_r = f;
            end
            check_eq($sformatf("slow_order%0d", i), 64'(j >= 0), 64'd1);
        end
        check_eq("slow_last_L", last_l, lw[lw.size()-1]);
        check_eq("slow_last_R", last_r, rw[rw.size()-1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
